data_mem_responder: RTL

- Memory-side responder for the pipeline's MEM-stage load/store requests; replaces the zero-latency data array with a multi-cycle, handshaked memory.
- Accepts one request at a time and counts down a programmable access latency.
- Performs size- and lane-correct reads and writes, then returns a one-cycle response.
- Drives a stall to the hazard unit while a request is outstanding.

---
 rtl/data_mem_responder_pkg.sv | 28 ++
 rtl/data_mem_responder_lane_steer.sv | 46 ++++
 rtl/data_mem_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared size codes, FSM state type and the alignment rule used by the
// multi-cycle data memory responder.
package mem_pkg;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_BYTE = 2'b11;

    localparam int unsigned LAT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_t;

    // Words need a 4-byte boundary, halves a 2-byte boundary; bytes never fault.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_WORD: return lane != 2'b00;
            SZ_HALF: return lane[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_lane_steer.sv
// Little-endian lane steering: merges store data into the addressed word and
// extracts a sign-extended load value for word, half and byte accesses.
module mem_lane_steer
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    output logic [31:0] write_word,
    output logic [3:0]  byte_en,
    output logic [31:0] load_value
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        write_word = old_word;
        byte_en    = '0;
        load_value = '0;
        sel_byte   = '0;
        sel_half   = '0;
        case (size)
            SZ_WORD: begin
                byte_en    = '1;
                write_word = store_data;
                load_value = old_word;
            end
            SZ_HALF: begin
                byte_en                                = lane[1] ? 4'b1100 : 4'b0011;
                write_word[{lane[1], 4'b0000} +: 16]   = store_data[15:0];
                sel_half                               = old_word[{lane[1], 4'b0000} +: 16];
                load_value                             = {{16{sel_half[15]}}, sel_half};
            end
            SZ_BYTE: begin
                byte_en                          = 4'b0001 << lane;
                write_word[{lane, 3'b000} +: 8]  = store_data[7:0];
                sel_byte                         = old_word[{lane, 3'b000} +: 8];
                load_value                       = {{24{sel_byte[7]}}, sel_byte};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked MEM-stage data memory: accepts one request, waits LATENCY cycles,
// performs one lane-correct access and returns a single-cycle response.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    input  logic [1:0]  ReqMemRead,
    input  logic [1:0]  ReqMemWrite,
    input  logic [31:0] ReqAddress,
    input  logic [31:0] ReqWriteData,
    output logic        ReqReady,
    output logic        RespValid,
    output logic [31:0] RespReadData,
    output logic        AlignError,
    output logic        Stall
);

    state_t state, state_next;
    logic [LAT_W-1:0] count, count_next;
    logic accept;

    logic [1:0]           rd_q, wr_q, lane_q;
    logic [ADDR_BITS-1:0] index_q;
    logic [31:0]          wdata_q;

    logic [31:0] mem [DEPTH] = '{default: '0};

    logic        has_op;
    logic [1:0]  op_size;
    logic        access_err;
    logic        mem_we;
    logic [31:0] old_word, write_word, load_value, read_next;
    logic [3:0]  byte_en;
    logic        addr_high_unused;

    // Out-of-range addresses wrap, so the upper address bits are ignored.
    assign addr_high_unused = ^ReqAddress[31:ADDR_BITS+2];

    assign has_op = (ReqMemRead != SZ_NONE) || (ReqMemWrite != SZ_NONE);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        accept     = 1'b0;
        ReqReady   = 1'b0;
        case (state)
            ST_IDLE: begin
                ReqReady = 1'b1;
                if (ReqValid && has_op) begin
                    accept     = 1'b1;
                    count_next = LAT_W'(LATENCY);
                    state_next = (LATENCY == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                count_next = count - 1'b1;
                if (count <= LAT_W'(1)) state_next = ST_ACCESS;
            end
            ST_ACCESS: state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        Stall = ReqValid && has_op && (state != ST_RESP);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_q    <= SZ_NONE;
            wr_q    <= SZ_NONE;
            lane_q  <= '0;
            index_q <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            rd_q    <= ReqMemRead;
            wr_q    <= ReqMemWrite;
            lane_q  <= ReqAddress[1:0];
            index_q <= ReqAddress[ADDR_BITS+1:2];
            wdata_q <= ReqWriteData;
        end
    end

    assign old_word = mem[index_q];
    assign op_size  = (wr_q != SZ_NONE) ? wr_q : rd_q;

    mem_lane_steer u_steer (
        .size       (op_size),
        .lane       (lane_q),
        .old_word   (old_word),
        .store_data (wdata_q),
        .write_word (write_word),
        .byte_en    (byte_en),
        .load_value (load_value)
    );

    always_comb begin
        access_err = ((rd_q != SZ_NONE) && (wr_q != SZ_NONE))
                   || misaligned(rd_q, lane_q)
                   || misaligned(wr_q, lane_q);
        mem_we     = (state == ST_ACCESS) && (wr_q != SZ_NONE) && !access_err;
        read_next  = ((rd_q != SZ_NONE) && !access_err) ? load_value : '0;
    end

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[index_q][8*i +: 8] <= write_word[8*i +: 8];
            end
        end
    end

    // Response data is captured at the end of ACCESS and held until the next one.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RespValid    <= 1'b0;
            AlignError   <= 1'b0;
            RespReadData <= '0;
        end else begin
            RespValid  <= (state == ST_ACCESS);
            AlignError <= (state == ST_ACCESS) && access_err;
            if (state == ST_ACCESS) RespReadData <= read_next;
        end
    end

endmodule
